// File: rtl/tff_count_sequencer.sv
// Start/stop/pause sequencer driving a bank of toggle flip-flops as a programmable counter.
// Every bank change (count, load, clear) is expressed as a per-bit toggle vector.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             up_dn,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] t_vec_s;
  logic [WIDTH-1:0] limit_r;
  logic             up_dn_r, auto_reload_r;
  logic             done_r, done_s;
  logic             busy_r;
  logic             load_s;
  logic [WIDTH-1:0] start_val_s, end_val_s;
  logic [WIDTH-1:0] step_up_s, step_dn_s;

  // Load/terminal values from the latched configuration.
  always_comb begin
    start_val_s = up_dn_r ? ZERO : limit_r;
    end_val_s   = up_dn_r ? limit_r : ZERO;
  end

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    step_up_s    = ZERO;
    step_dn_s    = ZERO;
    step_up_s[0] = 1'b1;
    step_dn_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      step_up_s[i] = step_up_s[i-1] & q_r[i-1];
      step_dn_s[i] = step_dn_s[i-1] & ~q_r[i-1];
    end
  end

  // Next-state and toggle-vector decode; stop > start > pause > count.
  always_comb begin
    state_s = state_r;
    t_vec_s = ZERO;
    done_s  = 1'b0;
    load_s  = 1'b0;
    if (stop) begin
      t_vec_s = q_r;
      state_s = IDLE;
    end else if (start) begin
      load_s  = 1'b1;
      t_vec_s = q_r ^ (up_dn ? ZERO : limit);
      state_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (pause) begin
            state_s = HOLD;
          end else if (q_r == end_val_s) begin
            done_s = 1'b1;
            if (auto_reload_r) begin
              t_vec_s = q_r ^ start_val_s;
            end else begin
              state_s = DONE;
            end
          end else begin
            t_vec_s = up_dn_r ? step_up_s : step_dn_s;
          end
        end
        HOLD: begin
          if (pause) begin
            state_s = HOLD;
          end else begin
            state_s = RUN;
          end
        end
        IDLE:    state_s = IDLE;
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State, bank, status and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      q_r           <= ZERO;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      up_dn_r       <= 1'b0;
      auto_reload_r <= 1'b0;
      limit_r       <= ZERO;
    end else begin
      state_r <= state_s;
      q_r     <= q_r ^ t_vec_s;
      done_r  <= done_s;
      busy_r  <= (state_s == RUN) || (state_s == HOLD);
      if (load_s) begin
        up_dn_r       <= up_dn;
        auto_reload_r <= auto_reload;
        limit_r       <= limit;
      end
    end
  end

  assign q     = q_r;
  assign t_vec = t_vec_s;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Randomized plus directed bench for tff_count_sequencer, checked every cycle
// against an arithmetic reference model; literal checks pin the model.
module tb_tff_count_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, pause, up_dn, auto_reload;
  logic [W-1:0] limit, q, t_vec;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 run, 2 hold, 3 done
  int           m_mode;
  logic [W-1:0] m_q, m_lim;
  logic         m_up, m_ar, m_done;

  tff_count_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .up_dn(up_dn), .auto_reload(auto_reload), .limit(limit),
    .q(q), .t_vec(t_vec), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_q = '0; m_lim = '0; m_up = 1'b0; m_ar = 1'b0; m_done = 1'b0;
  endtask

  // One clock: check registered outputs, drive inputs, check t_vec, advance model.
  task automatic cyc(input logic st, input logic sp, input logic pa,
                     input logic ud, input logic ar, input logic [W-1:0] lm);
    logic [W-1:0] nq, s_val, e_val;
    int           nmode;
    logic         nd;
    @(negedge clk);
    chk("q", q, m_q);
    chk("busy", busy, (m_mode == 1 || m_mode == 2));
    chk("done", done, m_done);
    start = st; stop = sp; pause = pa; up_dn = ud; auto_reload = ar; limit = lm;
    #1;
    nq = m_q; nmode = m_mode; nd = 1'b0;
    if (sp) begin
      nq = '0; nmode = 0;
    end else if (st) begin
      m_up = ud; m_ar = ar; m_lim = lm;
      nq = ud ? '0 : lm; nmode = 1;
    end else if (m_mode == 1) begin
      s_val = m_up ? '0 : m_lim;
      e_val = m_up ? m_lim : '0;
      if (pa) nmode = 2;
      else if (m_q == e_val) begin
        nd = 1'b1;
        if (m_ar) nq = s_val; else nmode = 3;
      end else nq = m_up ? m_q + 1'b1 : m_q - 1'b1;
    end else if (m_mode == 2) begin
      if (!pa) nmode = 1;
    end
    chk("t_vec", t_vec, m_q ^ nq);
    @(posedge clk);
    #1;
    m_q = nq; m_mode = nmode; m_done = nd;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    up_dn = 1'b0; auto_reload = 1'b0; limit = 4'd0;
    model_reset();
    #12;
    chk("rst_q", q, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tvec", t_vec, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_n(2);

    // 1: up to 5, no reload
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
    chk("t1_q0", q, 4'd0);
    idle_n(3);
    chk("t1_q3", q, 4'd3);
    chk("t1_tvec3", t_vec, 4'b0111);
    idle_n(2);
    chk("t1_q5", q, 4'd5);
    chk("t1_nodone", done, 1'b0);
    idle_n(1);
    chk("t1_done", done, 1'b1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_hold", q, 4'd5);
    idle_n(1);
    chk("t1_done_pulse", done, 1'b0);

    // 2: down from 5 with reload
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    chk("t2_q5", q, 4'd5);
    idle_n(5);
    chk("t2_q0", q, 4'd0);
    idle_n(1);
    chk("t2_reload", q, 4'd5);
    chk("t2_done", done, 1'b1);
    chk("t2_busy", busy, 1'b1);
    idle_n(1);
    chk("t2_q4", q, 4'd4);

    // 3: pause at q=2
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    idle_n(2);
    chk("t3_q2", q, 4'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t3_frozen", q, 4'd2);
    chk("t3_tvec", t_vec, 4'd0);
    idle_n(1);
    chk("t3_resume", q, 4'd2);
    idle_n(1);
    chk("t3_q3", q, 4'd3);

    // 4: stop at q=7
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
    idle_n(7);
    chk("t4_q7", q, 4'd7);
    stop = 1'b1; #1;
    chk("t4_tvec", t_vec, 4'b0111);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t4_clear", q, 4'd0);
    chk("t4_busy", busy, 1'b0);
    idle_n(3);
    chk("t4_nodone", done, 1'b0);

    // 5: full range with reload, then limit 0
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd15);
    idle_n(15);
    chk("t5_q15", q, 4'd15);
    idle_n(1);
    chk("t5_wrap", q, 4'd0);
    chk("t5_done", done, 1'b1);
    idle_n(1);
    chk("t5_q1", q, 4'd1);
    chk("t5_done_once", done, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("t5_l0_first", done, 1'b0);
    idle_n(1);
    chk("t5_l0_done", done, 1'b1);
    idle_n(1);
    chk("t5_l0_again", done, 1'b1);
    chk("t5_l0_q", q, 4'd0);

    // 6: async reset mid-count
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
    idle_n(6);
    chk("t6_q6", q, 4'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_q", q, 4'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
    chk("t6_restart", busy, 1'b1);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] lm;
      lm = $urandom_range(0, 1) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 15));
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), lm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
